// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO bank with direction, atomic set/clear, input sync and W1C edge interrupts
module wb_gpio_irq #(
   parameter int WIDTH = 16,
   parameter int SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] OUT_RESET = '0,
   parameter logic [WIDTH-1:0] DIR_RESET = '0
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic [31:0]      wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   input  logic [3:0]       wb_sel_i,
   input  logic             wb_we_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq_o
);
   typedef enum logic {IDLE, ACK} state_t;
   state_t state, state_nx;
   logic [2:0] adr;
   logic [2:0] prime_cnt;
   logic access, wr, primed, irq_q, unused;
   logic [31:0] bmask, rdata, rd_q;
   logic [WIDTH-1:0] wmask, wval, data_in, prev, data_out, dir, rise_en, fall_en, status, w1c, rise, fall;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   assign adr = wb_adr_i[4:2];
   assign access = (state == IDLE) && wb_cyc_i && wb_stb_i;
   assign wr = access && wb_we_i;
   assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wmask = bmask[WIDTH-1:0];
   assign wval = wb_dat_i[WIDTH-1:0] & wmask;
   assign data_in = sync_q[SYNC_STAGES-1];
   assign primed = prime_cnt == 3'(SYNC_STAGES + 1);
   assign w1c = (wr && adr == 3'd5) ? wval : '0;
   assign rise = primed ? (data_in & ~prev & rise_en) : '0;
   assign fall = primed ? (~data_in & prev & fall_en) : '0;
   assign gpio_o = data_out;
   assign gpio_oe = dir;
   assign irq_o = irq_q;
   assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, bmask};
   always_ff @(posedge wb_clk_i)
      state <= !wb_rst_ni ? IDLE : state_nx;
   always_comb
      state_nx = access ? ACK : IDLE;
   always_comb begin
      wb_ack_o = state == ACK;
      wb_dat_o = (state == ACK) ? rd_q : '0;
   end
   always_comb begin
      rdata = '0;
      case (adr)
         3'd0: rdata[WIDTH-1:0] = data_in;
         3'd1: rdata[WIDTH-1:0] = data_out;
         3'd2: rdata[WIDTH-1:0] = dir;
         3'd3: rdata[WIDTH-1:0] = rise_en;
         3'd4: rdata[WIDTH-1:0] = fall_en;
         3'd5: rdata[WIDTH-1:0] = status;
         default: rdata = '0;
      endcase
   end
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         rd_q <= '0;
         data_out <= OUT_RESET;
         dir <= DIR_RESET;
         rise_en <= '0;
         fall_en <= '0;
         status <= '0;
         irq_q <= 1'b0;
         prev <= '0;
         prime_cnt <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         if (access) rd_q <= rdata;
         if (wr && adr == 3'd1) data_out <= (data_out & ~wmask) | wval;
         else if (wr && adr == 3'd6) data_out <= data_out | wval;
         else if (wr && adr == 3'd7) data_out <= data_out & ~wval;
         if (wr && adr == 3'd2) dir <= (dir & ~wmask) | wval;
         if (wr && adr == 3'd3) rise_en <= (rise_en & ~wmask) | wval;
         if (wr && adr == 3'd4) fall_en <= (fall_en & ~wmask) | wval;
         status <= (status & ~w1c) | rise | fall;
         irq_q <= |status;
         prev <= data_in;
         sync_q[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         if (!primed) prime_cnt <= prime_cnt + 3'd1;
      end
   end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: self-checking bench with a read-expectation queue
module tb_wb_gpio_irq;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, cyc, stb, we, ack, irq;
   logic [31:0] adr, dat_i, dat_o;
   logic [3:0] sel;
   logic [15:0] gin, gout, goe;
   int checks = 0, failures = 0;
   logic [31:0] exp_q[$];

   wb_gpio_irq #(.WIDTH(16), .SYNC_STAGES(2), .OUT_RESET(16'hA5A5), .DIR_RESET(16'h00FF)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
      .gpio_i(gin), .gpio_o(gout), .gpio_oe(goe), .irq_o(irq));

   // lat: cycles to ack (0 = timeout, 100 = ack held past one cycle)
   task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat);
      lat = 0;
      rd = '0;
      @(negedge clk);
      cyc = 1; stb = 1; we = w; adr = {27'd0, a, 2'b00}; dat_i = d; sel = s;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (ack) begin lat = i; rd = dat_o; end
      end
      cyc = 0; stb = 0; we = 0;
      if (lat != 0) begin
         @(posedge clk); #1;
         if (ack) lat = 100;
      end
   endtask

   task automatic rd_check(input string name, input logic [2:0] a);
      logic [31:0] rd, e;
      int lat;
      bus(0, a, 32'd0, 4'hF, rd, lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 1) begin failures++; $display("FAIL %s_ack lat=%0d exp=1", name, lat); end
      checks++;
      if (rd !== e) begin failures++; $display("FAIL %s got=%h exp=%h", name, rd, e); end
   endtask

   task automatic test_reset();
      rst_n = 0; cyc = 1; stb = 1; we = 0; adr = 32'h4; dat_i = 0; sel = 4'hF; gin = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
      checks++; if (dat_o !== 32'd0) begin failures++; $display("FAIL rst_dat got=%h exp=0", dat_o); end
      checks++; if (gout !== 16'hA5A5) begin failures++; $display("FAIL rst_gpio_o got=%h exp=a5a5", gout); end
      checks++; if (goe !== 16'h00FF) begin failures++; $display("FAIL rst_gpio_oe got=%h exp=00ff", goe); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
      @(negedge clk);
      cyc = 0; stb = 0; rst_n = 1;
      @(posedge clk); #1;
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_abort_ack got=%b exp=0", ack); end
   endtask

   task automatic test_data_out();
      logic [31:0] rd;
      int lat;
      bus(1, 3'd1, 32'h1234, 4'b0001, rd, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL wr_ack lat=%0d exp=1", lat); end
      checks++; if (gout !== 16'hA534) begin failures++; $display("FAIL merge_gpio_o got=%h exp=a534", gout); end
      exp_q.push_back(32'h0000A534);
      rd_check("rd_data_out", 3'd1);
      exp_q.push_back(32'h000000FF);
      rd_check("rd_dir", 3'd2);
   endtask

   task automatic test_set_clr();
      logic [31:0] rd;
      int lat;
      bus(1, 3'd1, 32'h0, 4'hF, rd, lat);
      bus(1, 3'd6, 32'h000F, 4'hF, rd, lat);
      bus(1, 3'd7, 32'h0003, 4'hF, rd, lat);
      checks++; if (gout !== 16'h000C) begin failures++; $display("FAIL set_clr got=%h exp=000c", gout); end
      exp_q.push_back(32'h0);
      rd_check("rd_set_reg", 3'd6);
      exp_q.push_back(32'h0);
      rd_check("rd_clr_reg", 3'd7);
      bus(1, 3'd6, 32'hFF00, 4'b0001, rd, lat);
      checks++; if (gout !== 16'h000C) begin failures++; $display("FAIL set_masked got=%h exp=000c", gout); end
      bus(1, 3'd6, 32'hFF00, 4'b0010, rd, lat);
      exp_q.push_back(32'h0000FF0C);
      rd_check("rd_set_lane1", 3'd1);
   endtask

   task automatic test_data_in();
      logic [31:0] rd;
      int lat;
      gin = 16'h5A3C;
      repeat (4) @(posedge clk);
      exp_q.push_back(32'h00005A3C);
      rd_check("rd_data_in", 3'd0);
      bus(1, 3'd2, 32'hFFFF_FFFF, 4'hF, rd, lat);
      checks++; if (goe !== 16'hFFFF) begin failures++; $display("FAIL dir_oe got=%h exp=ffff", goe); end
      exp_q.push_back(32'h0000FFFF);
      rd_check("rd_dir_upper", 3'd2);
   endtask

   task automatic test_rise_irq();
      logic [31:0] rd;
      int lat;
      gin = 16'h0;
      repeat (4) @(posedge clk);
      bus(1, 3'd3, 32'h0001, 4'hF, rd, lat);
      @(negedge clk);
      gin[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
      exp_q.push_back(32'h1);
      rd_check("rd_status_rise", 3'd5);
      bus(1, 3'd5, 32'h1, 4'hF, rd, lat);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
      exp_q.push_back(32'h0);
      rd_check("rd_status_clr", 3'd5);
   endtask

   task automatic test_fall();
      logic [31:0] rd;
      int lat;
      bus(1, 3'd4, 32'h0002, 4'hF, rd, lat);
      @(negedge clk) gin[1] = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk) gin[1] = 1'b0;
      repeat (5) @(posedge clk);
      exp_q.push_back(32'h2);
      rd_check("rd_status_fall", 3'd5);
      bus(1, 3'd4, 32'h0, 4'hF, rd, lat);
      bus(1, 3'd5, 32'h2, 4'b0010, rd, lat);
      exp_q.push_back(32'h2);
      rd_check("rd_status_sticky", 3'd5);
      bus(1, 3'd5, 32'h2, 4'hF, rd, lat);
      exp_q.push_back(32'h0);
      rd_check("rd_status_fclr", 3'd5);
   endtask

   task automatic test_w1c_race();
      @(negedge clk) gin[0] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) gin[0] = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk) gin[0] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) gin[0] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 32'h14; dat_i = 32'h1; sel = 4'hF;
      @(posedge clk); #1;
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL race_ack got=%b exp=1", ack); end
      cyc = 0; stb = 0; we = 0;
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL race_irq got=%b exp=1", irq); end
      exp_q.push_back(32'h1);
      rd_check("rd_status_race", 3'd5);
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      @(negedge clk);
      cyc = 1; stb = 1; we = 0; adr = 32'h8;
      for (int i = 3; i >= 0; i--) begin
         @(posedge clk); #1;
         pat[i] = ack;
      end
      cyc = 0; stb = 0;
      checks++; if (pat !== 4'b1010) begin failures++; $display("FAIL b2b_ack got=%b exp=1010", pat); end
   endtask

   task automatic test_prime();
      logic [31:0] rd;
      int lat;
      @(negedge clk);
      gin = 16'hFFFF; rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1;
      bus(1, 3'd3, 32'hFFFF, 4'hF, rd, lat);
      repeat (6) @(posedge clk);
      #1;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL prime_irq got=%b exp=0", irq); end
      checks++; if (gout !== 16'hA5A5) begin failures++; $display("FAIL prime_gpio_o got=%h exp=a5a5", gout); end
      exp_q.push_back(32'h0);
      rd_check("rd_status_prime", 3'd5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_data_out();
      test_set_clr();
      test_data_in();
      test_rise_irq();
      test_fall();
      test_w1c_race();
      test_back_to_back();
      test_prime();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
